// File: rtl/cpu_wr_ctrl.sv
// rtl/cpu_wr_ctrl.sv - CPU register write controller: one write per cpu_wr high period
module cpu_wr_ctrl #(
    parameter int            DW   = 8,
    parameter logic [DW-1:0] RST1 = '0,
    parameter logic [DW-1:0] RST2 = '0,
    parameter logic [DW-1:0] RST3 = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_wr,
    input  logic [1:0]    cpu_addr,
    input  logic [DW-1:0] data_in,
    output logic          CS_reg1,
    output logic          CS_reg2,
    output logic          CS_reg3,
    output logic [DW-1:0] reg1,
    output logic [DW-1:0] reg2,
    output logic [DW-1:0] reg3,
    output logic          wr_ack,
    output logic          wr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic          wr_d;
    logic [1:0]    addr_q;
    logic [DW-1:0] data_q;
    logic          rise;

    // A write starts only on the 0->1 transition, so a long cpu_wr level commits once.
    assign rise = cpu_wr & ~wr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_d    <= 1'b0;
            addr_q  <= 2'd0;
            data_q  <= '0;
            CS_reg1 <= 1'b0;
            CS_reg2 <= 1'b0;
            CS_reg3 <= 1'b0;
            reg1    <= RST1;
            reg2    <= RST2;
            reg3    <= RST3;
            wr_ack  <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            wr_d <= cpu_wr;
            case (state)
                IDLE: begin
                    wr_ack <= 1'b0;
                    wr_err <= 1'b0;
                    if (rise) begin
                        addr_q  <= cpu_addr;
                        data_q  <= data_in;
                        CS_reg1 <= (cpu_addr == 2'd0);
                        CS_reg2 <= (cpu_addr == 2'd1);
                        CS_reg3 <= (cpu_addr == 2'd2);
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    // Commit from the latched copy; live inputs may already have moved on.
                    case (addr_q)
                        2'd0:    reg1 <= data_q;
                        2'd1:    reg2 <= data_q;
                        2'd2:    reg3 <= data_q;
                        default: ;
                    endcase
                    CS_reg1 <= 1'b0;
                    CS_reg2 <= 1'b0;
                    CS_reg3 <= 1'b0;
                    wr_ack  <= (addr_q != 2'd3);
                    wr_err  <= (addr_q == 2'd3);
                    state   <= HOLD;
                end
                HOLD: begin
                    wr_ack <= 1'b0;
                    wr_err <= 1'b0;
                    if (!cpu_wr) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    CS_reg1 <= 1'b0;
                    CS_reg2 <= 1'b0;
                    CS_reg3 <= 1'b0;
                    wr_ack  <= 1'b0;
                    wr_err  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_wr_ctrl.sv
// tb/tb_cpu_wr_ctrl.sv - randomized bench for cpu_wr_ctrl against a transaction-level model
module tb_cpu_wr_ctrl;
    localparam int         DW   = 8;
    localparam logic [7:0] RST1 = 8'h11;
    localparam logic [7:0] RST2 = 8'h22;
    localparam logic [7:0] RST3 = 8'h33;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [1:0]    cpu_addr = 2'd0;
    logic [DW-1:0] data_in = '0;
    logic          CS_reg1, CS_reg2, CS_reg3;
    logic [DW-1:0] reg1, reg2, reg3;
    logic          wr_ack, wr_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] e_reg [3];
    logic [2:0] e_cs;
    logic       e_ack, e_err;
    logic       prev_wr;
    logic       pend_v;
    logic [1:0] pend_a;
    logic [7:0] pend_d;

    cpu_wr_ctrl #(.DW(DW), .RST1(RST1), .RST2(RST2), .RST3(RST3)) dut (
        .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .data_in(data_in),
        .CS_reg1(CS_reg1), .CS_reg2(CS_reg2), .CS_reg3(CS_reg3),
        .reg1(reg1), .reg2(reg2), .reg3(reg3), .wr_ack(wr_ack), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        e_reg[0] = RST1;
        e_reg[1] = RST2;
        e_reg[2] = RST3;
        e_cs    = 3'b000;
        e_ack   = 1'b0;
        e_err   = 1'b0;
        prev_wr = 1'b0;
        pend_v  = 1'b0;
        pend_a  = 2'd0;
        pend_d  = 8'h00;
    endtask

    // One write per rising cpu_wr sample: selects show for a cycle, commit lands one edge later.
    task automatic model_edge(input logic wr, input logic [1:0] a, input logic [7:0] d);
        if (!rst) begin
            model_reset();
        end else begin
            e_cs  = 3'b000;
            e_ack = 1'b0;
            e_err = 1'b0;
            if (pend_v) begin
                if (pend_a == 2'd3) e_err = 1'b1;
                else begin
                    e_ack = 1'b1;
                    e_reg[pend_a] = pend_d;
                end
                pend_v = 1'b0;
            end
            if (wr && !prev_wr) begin
                pend_v = 1'b1;
                pend_a = a;
                pend_d = d;
                if (a != 2'd3) e_cs = 3'b001 << a;
            end
            prev_wr = wr;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".cs"},   {5'b0, CS_reg3, CS_reg2, CS_reg1}, {5'b0, e_cs});
        check({tag, ".ack"},  {7'b0, wr_ack}, {7'b0, e_ack});
        check({tag, ".err"},  {7'b0, wr_err}, {7'b0, e_err});
        check({tag, ".reg1"}, reg1, e_reg[0]);
        check({tag, ".reg2"}, reg2, e_reg[1]);
        check({tag, ".reg3"}, reg3, e_reg[2]);
    endtask

    task automatic cycle(input string tag, input logic wr, input logic [1:0] a, input logic [7:0] d);
        cpu_wr   = wr;
        cpu_addr = a;
        data_in  = d;
        @(posedge clk);
        model_edge(wr, a, d);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic write_op(input string tag, input logic [1:0] a, input logic [7:0] d,
                            input int hi, input int lo);
        for (int i = 0; i < hi; i++)
            cycle(tag, 1'b1, (i == 0) ? a : 2'($urandom_range(0, 3)), (i == 0) ? d : 8'($urandom));
        for (int i = 0; i < lo; i++)
            cycle(tag, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
    endtask

    initial begin
        model_reset();
        cycle("reset", 1'b0, 2'd0, 8'h00);
        cycle("reset", 1'b0, 2'd0, 8'h00);
        rst = 1'b1;
        cycle("idle", 1'b0, 2'd0, 8'h00);

        write_op("wr_reg2", 2'd1, 8'hA5, 5, 2);
        write_op("wr_inval", 2'd3, 8'hFF, 2, 2);

        cycle("latch", 1'b1, 2'd0, 8'h5A);
        cycle("latch", 1'b1, 2'd2, 8'h00);
        cycle("latch", 1'b0, 2'd2, 8'h00);
        cycle("latch", 1'b0, 2'd2, 8'h00);

        write_op("b2b", 2'd0, 8'h01, 2, 1);
        write_op("b2b", 2'd1, 8'h02, 2, 1);
        write_op("b2b", 2'd2, 8'h03, 2, 1);
        write_op("held", 2'd0, 8'h9C, 20, 2);

        // Reset while the write to reg3 sits in WRITE: it must vanish.
        cycle("midrst", 1'b1, 2'd2, 8'hC3);
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs("midrst.async");
        cycle("midrst", 1'b0, 2'd2, 8'hC3);
        rst = 1'b1;
        cycle("midrst", 1'b0, 2'd2, 8'hC3);
        write_op("postrst", 2'd2, 8'h77, 2, 1);

        // Release reset with cpu_wr already high: the first edge is a rise.
        rst = 1'b0;
        model_reset();
        cycle("rel_hi", 1'b1, 2'd1, 8'h3E);
        rst = 1'b1;
        write_op("rel_hi", 2'd1, 8'h4D, 3, 2);

        for (int r = 0; r < 60; r++)
            write_op("rand", 2'($urandom_range(0, 3)), 8'($urandom),
                     $urandom_range(2, 6), $urandom_range(1, 3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
